// File: rtl/adc_seq_ctrl_if.sv
// Result FIFO pop port of adc_seq_ctrl: valid/ready, data held while valid is high.
interface adc_seq_ctrl_if;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/adc_seq_ctrl.sv
// SAR ADC conversion sequencer: config check/latch, paced start pulses, done sync, result FIFO.
// Optional WAIT watchdog when ADC_SEQ_WDOG_EN is defined; otherwise WAIT is unbounded.
module adc_seq_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WDOG_CYCLES = 4095
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        single_req,
    input  logic [15:0]                 period,
    input  logic [15:0]                 cfg1_in,
    input  logic [15:0]                 cfg2_in,
    input  logic                        clr_err,
    output logic [15:0]                 adc_cfg1_out,
    output logic [15:0]                 adc_cfg2_out,
    output logic                        adc_start_out,
    input  logic                        adc_done_in,
    input  logic [15:0]                 adc_result_in,
    adc_seq_ctrl_if.master              rd,
    output logic                        busy,
    output logic                        cfg_err,
    output logic                        ovf_err,
    output logic                        wdog_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_L = FIFO_DEPTH[PW:0];

    typedef enum logic [2:0] {IDLE, START, GAP, WAIT, CAPTURE} state_t;

    state_t        state;
    logic          start_phase;
    logic [8:0]    start_cnt;
    logic [15:0]   gap_cnt;
    logic          done_s1, done_s2, done_s3;
    logic          done_rise;
    logic          trigger, cfg_ok;
    logic          push, pop, full, push_ok;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

`ifdef ADC_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
`else
    assign wdog_err = 1'b0;
`endif

    function automatic logic [8:0] osr_n(input logic [2:0] code);
        case (code)
            3'd0:    osr_n = 9'd1;
            3'd1:    osr_n = 9'd4;
            3'd2:    osr_n = 9'd16;
            3'd3:    osr_n = 9'd64;
            default: osr_n = 9'd256;
        endcase
    endfunction

    // START holds for 2 cycles and GAP runs load+1 cycles, so start-to-start is max(period,3).
    function automatic logic [15:0] gap_load(input logic [15:0] p);
        gap_load = (p < 16'd3) ? 16'd0 : p - 16'd3;
    endfunction

    assign trigger   = enable | single_req;
    assign cfg_ok    = (cfg1_in[5:3] <= 3'd4) && (cfg2_in[4:0] == cfg2_in[9:5]) &&
                       (cfg2_in[9:5] == cfg2_in[14:10]) && cfg2_in[15];
    assign done_rise = done_s2 & ~done_s3;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            done_s1 <= adc_done_in;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            start_phase   <= 1'b0;
            start_cnt     <= '0;
            gap_cnt       <= '0;
            adc_start_out <= 1'b0;
            adc_cfg1_out  <= '0;
            adc_cfg2_out  <= '0;
            cfg_err       <= 1'b0;
`ifdef ADC_SEQ_WDOG_EN
            wd_cnt        <= '0;
            wdog_err      <= 1'b0;
`endif
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (clr_err) begin
                cfg_err  <= 1'b0;
`ifdef ADC_SEQ_WDOG_EN
                wdog_err <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        if (cfg_ok) begin
                            adc_cfg1_out  <= cfg1_in;
                            adc_cfg2_out  <= cfg2_in;
                            start_cnt     <= osr_n(cfg1_in[5:3]);
                            start_phase   <= 1'b0;
                            adc_start_out <= 1'b1;
                            state         <= START;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (!start_phase) begin
                        start_phase <= 1'b1;
                    end else begin
                        start_phase   <= 1'b0;
                        adc_start_out <= 1'b0;
                        start_cnt     <= start_cnt - 9'd1;
                        gap_cnt       <= gap_load(period);
                        if (start_cnt == 9'd1) begin
                            state <= WAIT;
`ifdef ADC_SEQ_WDOG_EN
                            wd_cnt <= '0;
`endif
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) begin
                        adc_start_out <= 1'b1;
                        state         <= START;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                WAIT: begin
                    if (done_rise) begin
                        state <= CAPTURE;
                    end
`ifdef ADC_SEQ_WDOG_EN
                    else if (wd_cnt == WW'(WDOG_CYCLES - 1)) begin
                        wdog_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    if (enable) begin
                        start_cnt <= osr_n(adc_cfg1_out[5:3]);
                        gap_cnt   <= gap_load(period);
                        state     <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push        = (state == CAPTURE);
    assign pop         = rd.rd_valid & rd.rd_ready;
    assign full        = (fifo_level == DEPTH_L);
    assign push_ok     = push & (~full | pop);
    assign rd.rd_valid = (fifo_level != '0);
    assign rd.rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf_err    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (clr_err) ovf_err <= 1'b0;
            if (push && full && !pop) ovf_err <= 1'b1;
            if (push_ok) begin
                mem[wr_ptr] <= adc_result_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: ADC behavioural model, queue-based FIFO model checked every cycle, directed scenarios.
module tb_adc_seq_ctrl;
`ifdef ADC_SEQ_WDOG_EN
    localparam int WDOG = 100;
`else
    localparam int WDOG = 4095;
`endif
    localparam int DEPTH   = 4;
    localparam int ADC_DLY = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, single_req = 1'b0, clr_err = 1'b0;
    logic [15:0] period = 16'd10, cfg1 = 16'h0000, cfg2 = 16'h8842;
    logic [15:0] adc_cfg1_out, adc_cfg2_out;
    logic        adc_start_out;
    logic        adc_done_in = 1'b0;
    logic [15:0] adc_result_in = 16'h0000;
    logic        busy, cfg_err, ovf_err, wdog_err;
    logic [2:0]  fifo_level;

    adc_seq_ctrl_if rdif ();

    adc_seq_ctrl #(.FIFO_DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .enable(enable), .single_req(single_req), .period(period),
        .cfg1_in(cfg1), .cfg2_in(cfg2), .clr_err(clr_err),
        .adc_cfg1_out(adc_cfg1_out), .adc_cfg2_out(adc_cfg2_out), .adc_start_out(adc_start_out),
        .adc_done_in(adc_done_in), .adc_result_in(adc_result_in), .rd(rdif.master),
        .busy(busy), .cfg_err(cfg_err), .ovf_err(ovf_err), .wdog_err(wdog_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model state: expected FIFO contents, pending captures (due cycle, value), ADC conversion.
    logic [15:0] q[$];
    int          due_q[$];
    logic [15:0] val_q[$];
    int          start_times[$];
    bit          exp_ovf = 0, pop_flag = 0, rst_q = 1, clr_q = 0, chk_on = 0, hang = 0, st_prev = 0;
    int          model_n = 1, sub_idx = 0, sub_base = 0, st_base = 0, conv_cnt = 0;
    logic [15:0] res_val = 16'h5566;
    bit          full_before;

    always @(negedge clk) begin
        if (rst_q) begin
            q.delete(); due_q.delete(); val_q.delete();
            exp_ovf = 0;
        end else begin
            if (clr_q) exp_ovf = 0;
            full_before = (q.size() == DEPTH);
            if (pop_flag) void'(q.pop_front());
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                if (!full_before || pop_flag) q.push_back(val_q[0]);
                else exp_ovf = 1;
                void'(due_q.pop_front());
                void'(val_q.pop_front());
            end
        end
        if (chk_on) begin
            chk("rd_valid", 32'(rdif.rd_valid), 32'(q.size() > 0));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
            if (q.size() > 0) chk("rd_data", 32'(rdif.rd_data), 32'(q[0]));
        end
        pop_flag = (q.size() > 0) && rdif.rd_ready;
        rst_q    = rst;
        clr_q    = clr_err;
        // ADC: done drops at start, result + done rise ADC_DLY cycles later.
        if (adc_start_out && !st_prev) begin
            start_times.push_back(cyc);
            adc_done_in = 1'b0;
            conv_cnt    = ADC_DLY;
        end else if (conv_cnt > 0) begin
            conv_cnt--;
            if (conv_cnt == 0 && !hang) begin
                adc_result_in = res_val;
                adc_done_in   = 1'b1;
                sub_idx++;
                // done at cycle c -> synchronised rise -> CAPTURE -> visible in FIFO at c+4
                if ((sub_idx - sub_base) % model_n == 0) begin
                    due_q.push_back(cyc + 4);
                    val_q.push_back(res_val);
                end
                res_val += 16'h0111;
            end
        end
        st_prev = adc_start_out;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic arm(input int n);
        model_n = n; sub_base = sub_idx; st_base = start_times.size();
    endtask
    function automatic int nstarts();
        return start_times.size() - st_base;
    endfunction
    function automatic bit spacing_ok(input int groups, input int per);
        bit ok = 1;
        for (int g = 0; g < groups; g++)
            for (int k = 0; k < per - 1; k++)
                if (start_times[st_base + g*per + k + 1] - start_times[st_base + g*per + k] != 10) ok = 0;
        return ok;
    endfunction
    task automatic pulse_single(); single_req = 1'b1; tick(1); single_req = 1'b0; endtask
    task automatic pulse_clr();    clr_err = 1'b1;    tick(1); clr_err = 1'b0;    endtask
    task automatic pop1();         rdif.rd_ready = 1'b1; tick(1); rdif.rd_ready = 1'b0; endtask
    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) tick(1);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask
    task automatic wait_starts(input int n, input int bound);
        for (int i = 0; i < bound && nstarts() < n; i++) tick(1);
        chk("start_timeout", 32'(nstarts() >= n), 32'd1);
    endtask

    logic [15:0] exp3 [4];
    int t0;

    initial begin
        rdif.rd_ready = 1'b0;
        exp3 = '{16'h59AA, 16'h5DEE, 16'h6232, 16'h6676};
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_on = 1;
        chk("rst_start", 32'(adc_start_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_wdog_err", 32'(wdog_err), 32'd0);
        chk("rst_cfg1_out", 32'(adc_cfg1_out), 32'd0);

        // Single result, OSR code 0.
        cfg1 = 16'h1200; cfg2 = 16'h8842; arm(1);
        pulse_single();
        chk("single_start_t1", 32'(adc_start_out), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("cfg1_latched", 32'(adc_cfg1_out), 32'h1200);
        chk("cfg2_latched", 32'(adc_cfg2_out), 32'h8842);
        tick(1);
        chk("single_start_t2", 32'(adc_start_out), 32'd1);
        tick(1);
        chk("single_start_t3", 32'(adc_start_out), 32'd0);
        wait_idle(50);
        chk("single_nstarts", 32'(nstarts()), 32'd1);
        chk("single_data", 32'(rdif.rd_data), 32'h5566);
        chk("single_level", 32'(fifo_level), 32'd1);
        pop1();

        // OSR code 1 (N=4), continuous: four results, read back in order.
        cfg1 = 16'h0008; arm(4);
        enable = 1'b1;
        wait_starts(16, 400);
        enable = 1'b0;
        wait_idle(100);
        chk("osr4_nstarts", 32'(nstarts()), 32'd16);
        chk("osr4_spacing", 32'(spacing_ok(4, 4)), 32'd1);
        chk("osr4_level", 32'(fifo_level), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("osr4_readback", 32'(rdif.rd_data), 32'(exp3[j]));
            pop1();
        end

        // Bad configurations.
        cfg1 = 16'h0028; arm(1);
        pulse_single();
        chk("osr5_cfg_err", 32'(cfg_err), 32'd1);
        chk("osr5_busy", 32'(busy), 32'd0);
        tick(5);
        chk("osr5_no_start", 32'(nstarts()), 32'd0);
        pulse_clr();
        chk("clr_cfg_err", 32'(cfg_err), 32'd0);
        cfg1 = 16'h0000; cfg2 = 16'h9042;
        pulse_single();
        chk("delay_cfg_err", 32'(cfg_err), 32'd1);
        chk("cfg2_not_latched", 32'(adc_cfg2_out), 32'h8842);
        pulse_clr();
        cfg2 = 16'h0842;
        pulse_single();
        chk("bit15_cfg_err", 32'(cfg_err), 32'd1);
        pulse_clr();
        cfg2 = 16'h8842;
        chk("cfg_err_cleared", 32'(cfg_err), 32'd0);

        // Overflow: five results into a depth-4 FIFO with no reader.
        arm(1);
        enable = 1'b1;
        wait_starts(5, 300);
        enable = 1'b0;
        wait_idle(100);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(ovf_err), 32'd1);
        chk("ovf_head", 32'(rdif.rd_data), 32'h6787);
        pulse_clr();
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        // Pop coinciding with a push at full.
        arm(1);
        pulse_single();
        for (int i = 0; i < 100 && due_q.size() == 0; i++) tick(1);
        chk("push_pending", 32'(due_q.size() > 0), 32'd1);
        for (int i = 0; i < 20 && due_q.size() > 0 && cyc < due_q[0] - 1; i++) tick(1);
        pop1();
        chk("popush_level", 32'(fifo_level), 32'd4);
        chk("popush_ovf", 32'(ovf_err), 32'd0);
        chk("popush_head", 32'(rdif.rd_data), 32'h6898);
        wait_idle(50);

        // Done never arrives.
        arm(1); hang = 1;
        pulse_single();
        t0 = cyc;
`ifdef ADC_SEQ_WDOG_EN
        for (int i = 0; i < 300 && !wdog_err; i++) tick(1);
        chk("wdog_time", 32'(cyc), 32'(t0 + 2 + WDOG));
        chk("wdog_err", 32'(wdog_err), 32'd1);
        chk("wdog_idle", 32'(busy), 32'd0);
        pulse_clr();
        chk("wdog_cleared", 32'(wdog_err), 32'd0);
`else
        tick(150);
        chk("nowdog_busy", 32'(busy), 32'd1);
        chk("nowdog_err", 32'(wdog_err), 32'd0);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("nowdog_rst_idle", 32'(busy), 32'd0);
`endif
        hang = 0;

        // Reset in GAP with OSR code 2, then a full 16-start rerun.
        cfg1 = 16'h0010; arm(16);
        pulse_single();
        tick(24);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("rstgap_start", 32'(adc_start_out), 32'd0);
        chk("rstgap_busy", 32'(busy), 32'd0);
        chk("rstgap_level", 32'(fifo_level), 32'd0);
        tick(20);
        arm(16);
        pulse_single();
        wait_idle(400);
        chk("rerun_nstarts", 32'(nstarts()), 32'd16);
        chk("rerun_spacing", 32'(spacing_ok(1, 16)), 32'd1);
        chk("rerun_level", 32'(fifo_level), 32'd1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
